spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_slave_rx_if.sv | 27 ++
 rtl/spi_rx_fifo.sv | 44 ++++
 rtl/spi_slave_rx.sv | 108 ++++++++++
 tb/tb_spi_slave_rx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared sizing constants for the SPI slave receiver and its byte FIFO.
package spi_pkg;
   localparam int SPI_DATA_W      = 8;
   localparam int SPI_FIFO_DEPTH  = 4;
   localparam int SPI_SYNC_STAGES = 2;
   localparam int SPI_BIT_W       = $clog2(SPI_DATA_W);
   localparam int SPI_PTR_W       = $clog2(SPI_FIFO_DEPTH);
   localparam int SPI_CNT_W       = $clog2(SPI_FIFO_DEPTH + 1);

   typedef logic [SPI_DATA_W-1:0] spi_byte_t;
endpackage

// File: rtl/spi_slave_rx_if.sv
// Pin-level SPI inputs plus the FIFO read / status side of the receiver.
interface spi_slave_rx_if;
   import spi_pkg::*;

   logic                 GPIO_1_2;
   logic                 GPIO_1_0;
   logic                 GPIO_1_1;
   logic                 rd_en;
   logic                 err_clr;
   spi_byte_t            rd_data;
   logic                 empty;
   logic                 full;
   logic [SPI_CNT_W-1:0] count;
   logic                 frame_err;
   logic                 overrun_err;
   logic                 busy;

   modport slave (
      input  GPIO_1_2, GPIO_1_0, GPIO_1_1, rd_en, err_clr,
      output rd_data, empty, full, count, frame_err, overrun_err, busy
   );

   modport master (
      output GPIO_1_2, GPIO_1_0, GPIO_1_1, rd_en, err_clr,
      input  rd_data, empty, full, count, frame_err, overrun_err, busy
   );
endinterface

// File: rtl/spi_rx_fifo.sv
// Small synchronous byte FIFO; a write into a full FIFO succeeds when a pop happens in the same cycle.
module spi_rx_fifo
   import spi_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  spi_byte_t            wr_data,
   input  logic                 rd_en,
   output spi_byte_t            rd_data,
   output logic                 empty,
   output logic                 full,
   output logic [SPI_CNT_W-1:0] count
);
   spi_byte_t            mem [SPI_FIFO_DEPTH];
   logic [SPI_PTR_W-1:0] wr_ptr;
   logic [SPI_PTR_W-1:0] rd_ptr;
   logic                 push;
   logic                 pop;

   assign empty = (count == '0);
   assign full  = (count == SPI_CNT_W'(SPI_FIFO_DEPTH));
   assign pop   = rd_en & ~empty;
   assign push  = wr_en & (~full | pop);
   // Head is gated so the output reads zero whenever nothing is stored.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 style receive-only slave: pin synchronizers, SCLK-fall sampling, byte assembly
// into a 4-deep FIFO, and sticky frame/overrun error flags.
module spi_slave_rx
   import spi_pkg::*;
(
   input  logic           CLOCK_50,
   input  logic           rst,
   spi_slave_rx_if.slave  bus
);
   logic [SPI_SYNC_STAGES-1:0] sclk_sync;
   logic [SPI_SYNC_STAGES-1:0] mosi_sync;
   logic [SPI_SYNC_STAGES-1:0] ss_sync;
   logic                       sclk_h;
   logic                       ss_h;
   logic                       sclk_s;
   logic                       mosi_s;
   logic                       ss_s;

   logic                       fall_p0;
   logic                       vld_p1;
   logic                       ss_fall;
   logic                       ss_rise;
   logic                       end_pend;
   logic                       frame_chk;
   logic [SPI_BIT_W-1:0]       bit_cnt;
   logic [SPI_DATA_W-2:0]      shreg;
   spi_byte_t                  byte_p1;
   logic                       byte_done;
   logic                       drop;
   logic                       fifo_full;
   logic                       frame_err;
   logic                       overrun_err;

   // Stage p0: synchronize pins, keep one history flop for edge detection
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         sclk_h    <= 1'b0;
         ss_h      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SPI_SYNC_STAGES-2:0], bus.GPIO_1_2};
         mosi_sync <= {mosi_sync[SPI_SYNC_STAGES-2:0], bus.GPIO_1_0};
         ss_sync   <= {ss_sync[SPI_SYNC_STAGES-2:0], bus.GPIO_1_1};
         sclk_h    <= sclk_s;
         ss_h      <= ss_s;
      end
   end

   assign sclk_s  = sclk_sync[SPI_SYNC_STAGES-1];
   assign mosi_s  = mosi_sync[SPI_SYNC_STAGES-1];
   assign ss_s    = ss_sync[SPI_SYNC_STAGES-1];
   // Gating on the SS history keeps the fall that lands together with the SS rise.
   assign fall_p0 = ~sclk_s & sclk_h & ~ss_h;
   assign ss_fall = ~ss_s & ss_h;
   assign ss_rise = ss_s & ~ss_h;

   // Stage p1: sample MOSI one cycle after the detected fall
   assign byte_p1   = {shreg, mosi_s};
   assign byte_done = vld_p1 & (bit_cnt == SPI_BIT_W'(SPI_DATA_W - 1));
   assign drop      = byte_done & fifo_full & ~bus.rd_en;
   // The end-of-frame check waits until any sample still in flight has landed.
   assign frame_chk = end_pend & ~vld_p1 & ~ss_fall;

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         bit_cnt     <= '0;
         shreg       <= '0;
         end_pend    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         vld_p1 <= fall_p0;
         if (ss_fall) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end else if (vld_p1) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= byte_p1[SPI_DATA_W-2:0];
         end else if (frame_chk) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end
         end_pend    <= ss_rise | (end_pend & ~frame_chk & ~ss_fall);
         frame_err   <= ~bus.err_clr & (frame_err | (frame_chk & (bit_cnt != '0)));
         overrun_err <= ~bus.err_clr & (overrun_err | drop);
      end
   end

   spi_rx_fifo u_fifo (
      .clk     (CLOCK_50),
      .rst     (rst),
      .wr_en   (byte_done),
      .wr_data (byte_p1),
      .rd_en   (bus.rd_en),
      .rd_data (bus.rd_data),
      .empty   (bus.empty),
      .full    (fifo_full),
      .count   (bus.count)
   );

   assign bus.full        = fifo_full;
   assign bus.frame_err   = frame_err;
   assign bus.overrun_err = overrun_err;
   assign bus.busy        = ~ss_s;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: SPI master model plus a queue-based reference of bytes and error flags.
module tb_spi_slave_rx;
   import spi_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   spi_slave_rx_if bus ();

   spi_slave_rx dut (
      .CLOCK_50 (clk),
      .rst      (rst),
      .bus      (bus)
   );

   int        n_chk  = 0;
   int        n_fail = 0;
   logic [7:0] m_q[$];
   bit        m_fe   = 1'b0;
   bit        m_ovr  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expected result of one frame: every full 8 bits is a byte, any leftover bits are a frame error.
   task automatic model_frame(input logic [31:0] data, input int nbits);
      logic [7:0] v;
      for (int b = 0; b < nbits / 8; b++) begin
         v = 8'(data >> (nbits - 8 * (b + 1)));
         if (m_q.size() < 4) m_q.push_back(v);
         else m_ovr = 1'b1;
      end
      if (nbits % 8 != 0) m_fe = 1'b1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".count"}, 32'(bus.count), 32'(m_q.size()));
      chk({tag, ".empty"}, 32'(bus.empty), 32'(m_q.size() == 0));
      chk({tag, ".full"}, 32'(bus.full), 32'(m_q.size() == 4));
      chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_fe));
      chk({tag, ".overrun_err"}, 32'(bus.overrun_err), 32'(m_ovr));
      chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
      if (m_q.size() != 0) chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(m_q[0]));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".empty"}, 32'(bus.empty), 32'd1);
      chk({tag, ".full"}, 32'(bus.full), 32'd0);
      chk({tag, ".count"}, 32'(bus.count), 32'd0);
      chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'd0);
      chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'd0);
      chk({tag, ".overrun_err"}, 32'(bus.overrun_err), 32'd0);
   endtask

   // ss_end: 0 = SS rises with the last fall, 1 = one half-period later, 2 = SS stays low.
   // mode on the last fall: 1 = pop in the byte-complete cycle, 2 = err_clr there, 3 = latency probe.
   task automatic send_frame(input logic [31:0] data, input int nbits, input int h,
                             input int ss_end, input int mode);
      bus.GPIO_1_1 = 1'b0;
      wait_n(h);
      for (int k = 0; k < nbits; k++) begin
         bus.GPIO_1_2 = 1'b1;
         wait_n(h);
         bus.GPIO_1_2 = 1'b0;
         bus.GPIO_1_0 = data[nbits - 1 - k];
         if (k == nbits - 1 && ss_end == 0) bus.GPIO_1_1 = 1'b1;
         if (k == nbits - 1 && mode != 0) begin
            wait_n(3);
            case (mode)
               1:       begin
                           chk("same_cycle.head", 32'(bus.rd_data), 32'(m_q[0]));
                           bus.rd_en = 1'b1;
                        end
               2:       bus.err_clr = 1'b1;
               default: chk("latency.empty_before", 32'(bus.empty), 32'd1);
            endcase
            wait_n(1);
            bus.rd_en   = 1'b0;
            bus.err_clr = 1'b0;
            if (mode == 1) void'(m_q.pop_front());
            if (mode == 3) chk("latency.empty_after", 32'(bus.empty), 32'd0);
            wait_n(h - 4);
         end else begin
            wait_n(h);
         end
      end
      if (ss_end == 1) bus.GPIO_1_1 = 1'b1;
      if (ss_end != 2) wait_n(6);
   endtask

   task automatic frame(input logic [31:0] d, input int nb, input int h, input int ss_end, input int mode);
      send_frame(d, nb, h, ss_end, mode);
      model_frame(d, nb);
      if (mode == 2) begin
         m_fe  = 1'b0;
         m_ovr = 1'b0;
      end
   endtask

   task automatic pop_one(input string tag);
      if (m_q.size() != 0) chk({tag, ".pop_data"}, 32'(bus.rd_data), 32'(m_q[0]));
      bus.rd_en = 1'b1;
      wait_n(1);
      bus.rd_en = 1'b0;
      if (m_q.size() != 0) void'(m_q.pop_front());
      wait_n(1);
      check_state(tag);
   endtask

   task automatic clr_err();
      bus.err_clr = 1'b1;
      wait_n(1);
      bus.err_clr = 1'b0;
      m_fe  = 1'b0;
      m_ovr = 1'b0;
      wait_n(1);
   endtask

   initial begin
      int lens[6] = '{8, 8, 16, 5, 12, 24};
      rst          = 1'b1;
      bus.GPIO_1_2 = 1'b0;
      bus.GPIO_1_0 = 1'b0;
      bus.GPIO_1_1 = 1'b1;
      bus.rd_en    = 1'b0;
      bus.err_clr  = 1'b0;
      wait_n(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      wait_n(3);
      check_state("post_reset");

      // single byte, SS rising together with the 8th fall
      frame(32'hD7, 8, 8, 0, 3);
      check_state("d7");
      pop_one("d7.pop");

      // overflow by one frame, then drain in order
      for (int v = 1; v <= 5; v++) frame(32'(v), 8, 8, 0, 0);
      check_state("five");
      for (int i = 0; i < 4; i++) pop_one($sformatf("five.pop%0d", i));
      clr_err();
      check_state("five.clr");

      // refill, then overrun coinciding with err_clr, then completion coinciding with a pop
      for (int i = 0; i < 4; i++) frame(32'($urandom_range(0, 255)), 8, 5, 0, 0);
      check_state("refill");
      frame(32'h66, 8, 8, 0, 2);
      check_state("ovr_clr");
      frame(32'h77, 8, 8, 0, 1);
      check_state("same_cycle");
      for (int i = 0; i < 3; i++) pop_one($sformatf("same_cycle.pop%0d", i));
      chk("same_cycle.last", 32'(bus.rd_data), 32'h77);
      pop_one("same_cycle.pop3");

      // short frame, then a clean frame
      frame(32'h15, 5, 8, 1, 0);
      check_state("short");
      frame(32'hA5, 8, 8, 0, 0);
      check_state("after_short");
      pop_one("after_short.pop");
      clr_err();

      // reset in the middle of a frame
      frame(32'h11, 8, 6, 0, 0);
      send_frame(32'hF, 4, 8, 2, 0);
      chk("mid_frame.busy", 32'(bus.busy), 32'd1);
      rst          = 1'b1;
      bus.GPIO_1_1 = 1'b1;
      bus.GPIO_1_2 = 1'b0;
      wait_n(2);
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      m_q.delete();
      m_fe  = 1'b0;
      m_ovr = 1'b0;
      wait_n(4);
      frame(32'h3C, 8, 8, 0, 0);
      check_state("after_rst");
      pop_one("after_rst.pop");

      // two bytes in one frame at the fastest SCLK
      frame(32'hBEEF, 16, 3, 0, 0);
      check_state("multi");
      pop_one("multi.pop0");
      pop_one("multi.pop1");

      for (int it = 0; it < 40; it++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op < 6) begin
            frame($urandom, lens[$urandom_range(0, 5)], int'($urandom_range(3, 10)),
                  int'($urandom_range(0, 1)), 0);
            check_state($sformatf("rnd%0d.frame", it));
         end else if (op < 9) begin
            pop_one($sformatf("rnd%0d.pop", it));
         end else begin
            clr_err();
            check_state($sformatf("rnd%0d.clr", it));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
